// File: rtl/isa_instr_encoder.sv
// ============================================================================
// Module   : isa_instr_encoder
// Purpose  : Expands macro-ops into the 9-bit instruction word stream
//            (PREP / PSFT / final word, or a single word for plain ops).
// Options  : ENC_MIN_PREP_EN - skip leading all-zero immediate chunks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module isa_instr_encoder #(
  parameter int IMM_W = 18,
  parameter int OPR_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [OPR_W-1:0] in_arg,
  input  logic [IMM_W-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       out_instr,
  output logic             out_last,
  output logic             prep_active,
  output logic             err
);

  localparam int NCH = IMM_W / 6;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PREP   = 3'd1;
  localparam logic [2:0] S_PSFT   = 3'd2;
  localparam logic [2:0] S_FINAL  = 3'd3;
  localparam logic [2:0] S_SINGLE = 3'd4;

  logic [2:0]       state;
  logic [3:0]       op_q;
  logic [OPR_W-1:0] arg_q;
  logic [IMM_W-1:0] imm_q;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    top_idx;

  function automatic logic [5:0] chunk_of(input logic [IMM_W-1:0] v,
                                          input logic [CW-1:0] idx);
    chunk_of = 6'd0;
    for (int j = 0; j < NCH; j++)
      if (idx == CW'(j)) chunk_of = v[6*j +: 6];
  endfunction

  // Index of the chunk carried by the PREP word (k-1).
  function automatic logic [CW-1:0] top_chunk(input logic [IMM_W-1:0] v);
`ifdef ENC_MIN_PREP_EN
    top_chunk = '0;
    for (int j = 0; j < NCH; j++)
      if (v[6*j +: 6] != 6'd0) top_chunk = CW'(j);
`else
    top_chunk = CW'(NCH - 1);
    if (v == '0) top_chunk = CW'(NCH - 1);
`endif
  endfunction

  function automatic logic is_prefixed(input logic [3:0] op);
    is_prefixed = (op >= 4'd6) && (op <= 4'd10);
  endfunction

  function automatic logic [8:0] final_word(input logic [3:0] op,
                                            input logic [OPR_W-1:0] arg);
    case (op)
      4'd6:    final_word = {3'b000, arg};
      4'd7:    final_word = {3'b001, arg};
      4'd8:    final_word = {3'b010, arg};
      4'd9:    final_word = {3'b011, arg};
      default: final_word = {3'b100, arg};
    endcase
  endfunction

  function automatic logic [8:0] single_word(input logic [3:0] op,
                                             input logic [OPR_W-1:0] arg);
    case (op)
      4'd0:    single_word = {3'b001, arg[5:1], 1'b1};
      4'd1:    single_word = {3'b001, arg[5:1], 1'b0};
      4'd2:    single_word = {3'b010, arg};
      4'd3:    single_word = {3'b011, arg};
      4'd4:    single_word = {3'b100, arg};
      4'd5:    single_word = {3'b101, arg};
      default: single_word = {3'b111, 6'd0};
    endcase
  endfunction

  assign in_ready = (state == S_IDLE);
  assign top_idx  = top_chunk(in_imm);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      op_q        <= 4'd0;
      arg_q       <= '0;
      imm_q       <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_instr   <= 9'd0;
      out_last    <= 1'b0;
      prep_active <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= in_op;
            arg_q <= in_arg;
            imm_q <= in_imm;
            if (is_prefixed(in_op)) begin
              cnt       <= top_idx;
              out_instr <= {3'b000, chunk_of(in_imm, top_idx)};
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              state     <= S_PREP;
            end else if (in_op >= 4'd12) begin
              err <= 1'b1;
            end else begin
              out_instr <= single_word(in_op, in_arg);
              out_valid <= 1'b1;
              out_last  <= 1'b1;
              state     <= S_SINGLE;
            end
          end
        end
        // cnt holds the index of the chunk currently on out_instr.
        S_PREP, S_PSFT: begin
          if (out_ready) begin
            prep_active <= 1'b1;
            if (cnt != '0) begin
              cnt       <= cnt - 1'b1;
              out_instr <= {3'b101, chunk_of(imm_q, cnt - 1'b1)};
              state     <= S_PSFT;
            end else begin
              out_instr <= final_word(op_q, arg_q);
              out_last  <= 1'b1;
              state     <= S_FINAL;
            end
          end
        end
        S_FINAL: begin
          if (out_ready) begin
            prep_active <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_SINGLE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_isa_instr_encoder.sv
// Scoreboard bench for isa_instr_encoder: stimulus pushes expected words,
// a negedge monitor pops and compares every transferred word.
`default_nettype none

module tb_isa_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [5:0]  in_arg;
  logic [17:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_instr;
  logic        out_last;
  logic        prep_active;
  logic        err;

  int checks = 0;
  int failures = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  isa_instr_encoder #(.IMM_W(18), .OPR_W(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_arg(in_arg), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_last(out_last),
    .prep_active(prep_active), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a word seen valid&&ready at negedge transfers at the next posedge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      logic [9:0] e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word: got instr=0x%03h last=%0b expected none", out_instr, out_last);
      end else begin
        e = sb.pop_front();
        if ({out_last, out_instr} !== e) begin
          failures++;
          $display("FAIL word: got instr=0x%03h last=%0b expected instr=0x%03h last=%0b",
                   out_instr, out_last, e[8:0], e[9]);
        end
      end
    end
  end

  task automatic expect_word(input logic [8:0] w, input logic last);
    sb.push_back({last, w});
  endtask

  task automatic send(input logic [3:0] op, input logic [5:0] arg, input logic [17:0] imm);
    bit done = 0;
    in_op = op; in_arg = arg; in_imm = imm; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 100 && !idle; i++) begin
      if (sb.size() == 0 && !out_valid) idle = 1;
      else begin @(posedge clk); #1; end
    end
    check("drain_idle", {31'd0, idle}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_arg = 6'd0; in_imm = 18'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", {23'd0, out_instr}, 32'd0);
    check("rst_prep", {31'd0, prep_active}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_err", {31'd0, err}, 32'd0);

    // Plain single-word ops
    expect_word(9'h045, 1'b1); send(4'd0, 6'h04, 18'h3FFFF);
    expect_word(9'h044, 1'b1); send(4'd1, 6'h04, 18'h0);
    expect_word(9'h1C0, 1'b1); send(4'd11, 6'h3F, 18'h0);
    expect_word(9'h095, 1'b1); send(4'd2, 6'h15, 18'h0);
    expect_word(9'h0C0, 1'b1); send(4'd3, 6'h00, 18'h0);
    expect_word(9'h101, 1'b1); send(4'd4, 6'h01, 18'h0);
    expect_word(9'h17F, 1'b1); send(4'd5, 6'h3F, 18'h0);
    wait_idle();

    // LW with prep_active tracking
    expect_word(9'h012, 1'b0); expect_word(9'h14D, 1'b0);
    expect_word(9'h145, 1'b0); expect_word(9'h083, 1'b1);
    send(4'd8, 6'h03, 18'h12345);
    check("prep_before_xfer", {31'd0, prep_active}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("prep_mid", {31'd0, prep_active}, 32'd1);
    end
    @(posedge clk); #1;
    check("prep_after_final", {31'd0, prep_active}, 32'd0);
    wait_idle();

    // ANDI with leading zero chunks
`ifdef ENC_MIN_PREP_EN
    expect_word(9'h02A, 1'b0); expect_word(9'h000, 1'b1);
`else
    expect_word(9'h000, 1'b0); expect_word(9'h140, 1'b0);
    expect_word(9'h16A, 1'b0); expect_word(9'h000, 1'b1);
`endif
    send(4'd6, 6'h00, 18'h0002A);
    wait_idle();

    // SW top chunk only; SAVE with zero top chunk
    expect_word(9'h03F, 1'b0); expect_word(9'h140, 1'b0);
    expect_word(9'h140, 1'b0); expect_word(9'h0EA, 1'b1);
    send(4'd9, 6'h2A, 18'h3F000);
`ifdef ENC_MIN_PREP_EN
    expect_word(9'h001, 1'b0); expect_word(9'h140, 1'b0); expect_word(9'h101, 1'b1);
`else
    expect_word(9'h000, 1'b0); expect_word(9'h141, 1'b0);
    expect_word(9'h140, 1'b0); expect_word(9'h101, 1'b1);
`endif
    send(4'd10, 6'h01, 18'h00040);
    wait_idle();

    // Backpressure mid-sequence; later input changes must not leak in
    expect_word(9'h012, 1'b0); expect_word(9'h14D, 1'b0);
    expect_word(9'h145, 1'b0); expect_word(9'h083, 1'b1);
    send(4'd8, 6'h03, 18'h12345);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_imm = 18'h3FFFF; in_arg = 6'h3F; in_op = 4'd11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_instr", {23'd0, out_instr}, 32'h14D);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    wait_idle();

    // Illegal opcode
    send(4'd13, 6'h05, 18'h0);
    check("illegal_err", {31'd0, err}, 32'd1);
    check("illegal_no_valid", {31'd0, out_valid}, 32'd0);
    check("illegal_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("illegal_err_pulse", {31'd0, err}, 32'd0);
    check("illegal_no_valid2", {31'd0, out_valid}, 32'd0);

    // Reset after the second LW word
    expect_word(9'h012, 1'b0); expect_word(9'h14D, 1'b0);
    expect_word(9'h145, 1'b0); expect_word(9'h083, 1'b1);
    send(4'd8, 6'h03, 18'h12345);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("pre_rst_remaining", sb.size(), 32'd2);
    sb.delete();
    @(posedge clk); #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_prep", {31'd0, prep_active}, 32'd0);
    reset = 1'b1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("postrst_no_valid", {31'd0, out_valid}, 32'd0);
    end

    // Recovery after reset
    expect_word(9'h044, 1'b1); send(4'd1, 6'h05, 18'h0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
